// File: rtl/sbox_arb_pkg.sv
// Shared definitions for the masked S-box arbiter: tag encoding and default S-box latency.
package sbox_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DP   = 2'd1,
        TAG_KS   = 2'd2
    } tag_e;

    localparam int SBOX_LAT_DEF = 6;

endpackage

// File: rtl/sbox_tag_pipe.sv
// Ownership tag delay line that runs alongside the S-box pipeline.
// Also reports whether any token still occupies a computing stage.
module sbox_tag_pipe
    import sbox_arb_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_e tag_in,
    output tag_e tag_out,
    output logic busy
);

    tag_e tag_q [SBOX_LAT];
    tag_e tag_d [SBOX_LAT];

    always_comb begin
        tag_d[0] = tag_in;
        for (int k = 1; k < SBOX_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SBOX_LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[SBOX_LAT-1];

    // The output stage is emitting this cycle and no longer needs fresh randomness.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < SBOX_LAT - 1; k++) begin
            busy = busy | (tag_q[k] != TAG_NONE);
        end
    end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin sharing of one masked pipelined S-box between the round datapath and key schedule.
// Optional SBOX_ARB_IDLE_ZERO_EN: drive all-zero shares into the S-box on non-issue cycles.
module sbox_share_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int d        = 2,
    parameter int SBOX_LAT = SBOX_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dp_valid,
    output logic           dp_ready,
    input  logic [8*d-1:0] dp_data,
    input  logic           ks_valid,
    output logic           ks_ready,
    input  logic [8*d-1:0] ks_data,
    input  logic           prng_valid,
    output logic           prng_ready,
    output logic [8*d-1:0] sbox_in,
    input  logic [8*d-1:0] sbox_out,
    output logic [8*d-1:0] rsp_data,
    output logic           dp_rsp_valid,
    output logic           ks_rsp_valid,
    output logic           busy,
    output logic           rnd_err
);

    // ptr_q: 0 favours DP, 1 favours KS on contention
    logic ptr_q, ptr_d;
    logic rnd_err_q, rnd_err_d;
    logic issue, sel_ks, pipe_busy;
    logic [8*d-1:0] mux_data;
    tag_e issue_tag, out_tag;

    always_comb begin
        issue = prng_valid & ~rst & (dp_valid | ks_valid);
        if (dp_valid & ks_valid) begin
            sel_ks = ptr_q;
        end else if (ks_valid) begin
            sel_ks = 1'b1;
        end else if (dp_valid) begin
            sel_ks = 1'b0;
        end else begin
            sel_ks = ptr_q;
        end
        dp_ready  = issue & ~sel_ks;
        ks_ready  = issue & sel_ks;
        issue_tag = TAG_NONE;
        if (issue) begin
            issue_tag = sel_ks ? TAG_KS : TAG_DP;
        end
        ptr_d     = issue ? ~sel_ks : ptr_q;
        rnd_err_d = rnd_err_q | (pipe_busy & ~prng_valid);
        mux_data  = sel_ks ? ks_data : dp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 1'b0;
            rnd_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rnd_err_q <= rnd_err_d;
        end
    end

`ifdef SBOX_ARB_IDLE_ZERO_EN
    assign sbox_in = issue ? mux_data : '0;
`else
    assign sbox_in = mux_data;
`endif

    sbox_tag_pipe #(
        .SBOX_LAT (SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (out_tag),
        .busy    (pipe_busy)
    );

    assign busy         = pipe_busy & ~rst;
    assign prng_ready   = issue | busy;
    assign rsp_data     = sbox_out;
    assign dp_rsp_valid = ~rst & (out_tag == TAG_DP);
    assign ks_rsp_valid = ~rst & (out_tag == TAG_KS);
    assign rnd_err      = rnd_err_q;

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter with a behavioural masked AES S-box and a response scoreboard.
module tb_sbox_share_arbiter;

    localparam int D   = 2;
    localparam int LAT = 6;
    localparam logic [7:0] SALT_DP = 8'h3C;
    localparam logic [7:0] SALT_KS = 8'hC3;

    logic           clk;
    logic           rst;
    logic           dp_valid, dp_ready, ks_valid, ks_ready;
    logic [8*D-1:0] dp_data, ks_data, sbox_in, sbox_out, rsp_data;
    logic           prng_valid, prng_ready;
    logic           dp_rsp_valid, ks_rsp_valid, busy, rnd_err;

    sbox_share_arbiter #(.d(D), .SBOX_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .dp_data      (dp_data),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .ks_data      (ks_data),
        .prng_valid   (prng_valid),
        .prng_ready   (prng_ready),
        .sbox_in      (sbox_in),
        .sbox_out     (sbox_out),
        .rsp_data     (rsp_data),
        .dp_rsp_valid (dp_rsp_valid),
        .ks_rsp_valid (ks_rsp_valid),
        .busy         (busy),
        .rnd_err      (rnd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1B;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [8*D-1:0] share(input logic [7:0] b, input logic [7:0] salt);
        logic [8*D-1:0] r;
        logic [7:0]     m;
        logic           p;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            p = b[i];
            for (int j = 0; j < D - 1; j++) begin
                m = salt ^ (8'(j) * 8'h47) ^ {b[3:0], b[7:4]};
                r[D*i+j] = m[i];
                p = p ^ m[i];
            end
            r[D*i+D-1] = p;
        end
        return r;
    endfunction

    function automatic logic [7:0] recomb(input logic [8*D-1:0] x);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = ^x[D*i +: D];
        return v;
    endfunction

    // Behavioural S-box: recombine, substitute, re-share, LAT register stages.
    logic [8*D-1:0] mdl_q [LAT];
    always @(posedge clk) begin
        mdl_q[0] <= share(aes_sbox(recomb(sbox_in)), 8'h77);
        for (int k = 1; k < LAT; k++) mdl_q[k] <= mdl_q[k-1];
    end
    assign sbox_out = mdl_q[LAT-1];

    typedef struct {
        logic       ks;
        logic [7:0] val;
        int         due;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    logic           s_busy, s_rnd, s_prr;
    logic [8*D-1:0] s_sbin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dv, input logic kv, input logic pv, input logic r,
                        input logic [7:0] db, input logic [7:0] kb,
                        input logic edr, input logic ekr);
        exp_t e;
        dp_valid   = dv;
        ks_valid   = kv;
        prng_valid = pv;
        rst        = r;
        dp_data    = share(db, SALT_DP);
        ks_data    = share(kb, SALT_KS);
        @(negedge clk);
        chk("dp_ready", dp_ready, edr);
        chk("ks_ready", ks_ready, ekr);
        s_busy = busy;
        s_rnd  = rnd_err;
        s_prr  = prng_ready;
        s_sbin = sbox_in;
        if (dp_ready) sb.push_back('{ks: 1'b0, val: aes_sbox(db), due: cyc + LAT});
        if (ks_ready) sb.push_back('{ks: 1'b1, val: aes_sbox(kb), due: cyc + LAT});
        if (dp_rsp_valid || ks_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {dp_rsp_valid, ks_rsp_valid}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("rsp_ks_owner", ks_rsp_valid, e.ks);
                chk("rsp_dp_owner", dp_rsp_valid, !e.ks);
                chk("rsp_data", recomb(rsp_data), e.val);
                chk("rsp_cycle", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("rsp_missing", dp_rsp_valid | ks_rsp_valid, 1'b1);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        dp_valid = 1'b0; ks_valid = 1'b0; prng_valid = 1'b0; rst = 1'b1;
        dp_data = '0; ks_data = '0;

        // reset with requests pending: no grants, quiet outputs
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_prng_ready", s_prr, 1'b0);
        chk("rst_rnd_err", s_rnd, 1'b0);
        chk("rst_dp_rsp", dp_rsp_valid, 1'b0);
        chk("rst_ks_rsp", ks_rsp_valid, 1'b0);

        // single DP byte 0x53 -> 0xED, then single KS byte 0x00 -> 0x63
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 8'h00, 1'b1, 1'b0);
        chk("dp_sbox_in", recomb(s_sbin), 8'h53);
        idle(LAT + 2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(LAT + 2);

        // contention: grants alternate starting with DP
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h22, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h44, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0);
        idle(LAT + 2);

        // PRNG stall with empty pipe: no issue, no error, DP wins once randomness returns
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h9A, 8'h00, 1'b0, 1'b0);
            chk("stall_rnd_err", s_rnd, 1'b0);
            chk("stall_prng_ready", s_prr, 1'b0);
`ifdef SBOX_ARB_IDLE_ZERO_EN
            chk("stall_sbox_in", s_sbin, '0);
`else
            chk("stall_sbox_in", s_sbin, share(8'h9A, SALT_DP));
`endif
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h9A, 8'h00, 1'b1, 1'b0);
        chk("issue_prng_ready", s_prr, 1'b1);
        idle(LAT + 2);

        // starvation: randomness drops while a token is in flight
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h7E, 8'h00, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("starve_rnd_err_c3", s_rnd, 1'b0);
        chk("starve_busy_c3", s_busy, 1'b1);
        chk("starve_prng_ready_c3", s_prr, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("starve_rnd_err_c4", s_rnd, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(2);
        chk("starve_rnd_err_sticky", s_rnd, 1'b1);
        chk("starve_busy_drained", s_busy, 1'b0);

        // reset mid-flight: three tokens dropped, pointer back to DP
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 8'h05, 1'b0, 1'b0);
        chk("midrst_busy", s_busy, 1'b0);
        sb.delete();
        idle(LAT + 1);
        chk("midrst_busy_after", s_busy, 1'b0);
        chk("midrst_rnd_err", s_rnd, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h05, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 1'b1);
        idle(LAT + 2);

        // idle S-box input: pointer now favours DP
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 8'h4B, 1'b0, 1'b0);
`ifdef SBOX_ARB_IDLE_ZERO_EN
        chk("idle_sbox_in", s_sbin, '0);
`else
        chk("idle_sbox_in", s_sbin, share(8'hA1, SALT_DP));
`endif
        chk("idle_prng_ready", s_prr, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
